// File: rtl/calc_input_sched.sv
// calc_input_sched: merges keypad (and optional UART) keys into a FIFO
// and paces them to the calculator. Build macro: CALC_SCHED_UART_EN.
module calc_input_sched #(
    parameter int FIFO_DEPTH  = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int RES_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       kp_valid,
    input  logic [7:0] kp_char,
    output logic       kp_ready,
    input  logic       rx_valid,
    input  logic [7:0] rx_char,
    output logic       rx_ready,
    output logic       btn_valid,
    output logic [7:0] btn_char,
    input  logic       result_valid,
    output logic       busy,
    output logic [2:0] fifo_level,
    output logic [7:0] drop_cnt,
    output logic       err_timeout
);

    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CMAX = (RES_TIMEOUT > GAP_CYCLES) ? RES_TIMEOUT : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [2:0] DEPTH   = 3'(FIFO_DEPTH);
    localparam logic [7:0] KEY_CLR = 8'h43;
    localparam logic [7:0] KEY_EQ  = 8'h3D;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP, WAIT_RES} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [2:0]    count_q, free;
    logic          run_q, err_q, set_err;
    logic [7:0]    drop_q, head;
    logic          kp_acc, kp_leg, rx_acc, rx_leg, rx_clr;
    logic          flush, pop, clr_issue;
    logic [1:0]    n_push, n_acc, n_drop;
    logic [8:0]    drop_sum;

    function automatic logic is_legal(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) || c == 8'h2B || c == 8'h2D ||
               c == 8'h2A || c == KEY_EQ || c == KEY_CLR || c == 8'h08;
    endfunction

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign free   = DEPTH - count_q;
    assign kp_acc = kp_valid && kp_ready;
    assign kp_leg = kp_acc && is_legal(kp_char);

`ifdef CALC_SCHED_UART_EN
    logic last_kp_q;

    // One free slot with both offering: the loser of the previous contest wins.
    assign kp_ready = run_q && (free >= 3'd2 ||
                      (free == 3'd1 && !(rx_valid && last_kp_q)));
    assign rx_ready = run_q && (free >= 3'd2 ||
                      (free == 3'd1 && !(kp_valid && !last_kp_q)));
    assign rx_acc   = rx_valid && rx_ready;
    assign rx_leg   = rx_acc && is_legal(rx_char);
    assign rx_clr   = rx_leg && rx_char == KEY_CLR;

    // Remember who won the last single-slot contest; resets favouring keypad.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_kp_q <= 1'b0;
        else if (kp_valid && rx_valid && free == 3'd1 && run_q)
            last_kp_q <= kp_acc;
    end
`else
    logic unused_rx;

    assign unused_rx = ^{rx_valid, rx_char};
    assign kp_ready  = run_q && (free != 3'd0);
    assign rx_ready  = 1'b0;
    assign rx_acc    = 1'b0;
    assign rx_leg    = 1'b0;
    assign rx_clr    = 1'b0;
`endif

    assign flush     = (kp_leg && kp_char == KEY_CLR) || rx_clr;
    assign n_push    = {1'b0, kp_leg} + {1'b0, rx_leg};
    assign n_acc     = {1'b0, kp_acc} + {1'b0, rx_acc};
    assign n_drop    = flush ? n_acc - 2'd1 : n_acc - n_push;
    assign pop       = state_q == ISSUE;
    assign head      = mem[rd_q];
    assign clr_issue = pop && head == KEY_CLR;
    assign drop_sum  = {1'b0, drop_q} + {7'b0, n_drop};

    // FIFO storage and pointers; a clear collapses the queue to a lone "C".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else if (flush) begin
            mem[0]  <= KEY_CLR;
            rd_q    <= '0;
            wr_q    <= inc('0);
            count_q <= 3'd1;
        end else begin
            if (kp_leg) mem[wr_q] <= kp_char;
            if (rx_leg) mem[kp_leg ? inc(wr_q) : wr_q] <= rx_char;
            if (pop) rd_q <= inc(rd_q);
            if (n_push == 2'd2) wr_q <= inc(inc(wr_q));
            else if (n_push == 2'd1) wr_q <= inc(wr_q);
            count_q <= count_q + {1'b0, n_push} - {2'b0, pop};
        end
    end

    // Scheduler next state: issue, pace, and wait for "=" results.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        set_err = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q != 3'd0 || n_push != 2'd0) state_d = ISSUE;
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = (head == KEY_EQ) ? WAIT_RES : GAP;
            end
            GAP: begin
                if (cnt_q == CW'(GAP_CYCLES - 1)) state_d = IDLE;
                else cnt_d = cnt_q + 1'b1;
            end
            WAIT_RES: begin
                if (result_valid || flush) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(RES_TIMEOUT - 1)) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    set_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Scheduler state, ready enable, sticky timeout and drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            err_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= 1'b1;
            if (set_err) err_q <= 1'b1;
            else if (clr_issue) err_q <= 1'b0;
            drop_q  <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    assign btn_valid   = pop;
    assign btn_char    = pop ? head : 8'h00;
    assign busy        = count_q != 3'd0 || state_q != IDLE;
    assign fifo_level  = count_q;
    assign drop_cnt    = drop_q;
    assign err_timeout = err_q && !clr_issue;

endmodule

// File: tb/tb_calc_input_sched.sv
// tb_calc_input_sched: vector table, corner sequences and random traffic
// checked against a queue-based model of the key scheduler.
module tb_calc_input_sched;

`ifdef CALC_SCHED_UART_EN
    localparam bit UART = 1'b1;
`else
    localparam bit UART = 1'b0;
`endif
    localparam int DEPTH = 4;
    localparam int GAPC  = 2;
    localparam int RTO   = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       kp_valid = 1'b0;
    logic [7:0] kp_char = 8'h00;
    logic       kp_ready;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_char = 8'h00;
    logic       rx_ready;
    logic       btn_valid;
    logic [7:0] btn_char;
    logic       result_valid = 1'b0;
    logic       busy;
    logic [2:0] fifo_level;
    logic [7:0] drop_cnt;
    logic       err_timeout;

    calc_input_sched #(
        .FIFO_DEPTH (DEPTH),
        .GAP_CYCLES (GAPC),
        .RES_TIMEOUT(RTO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .kp_valid    (kp_valid),
        .kp_char     (kp_char),
        .kp_ready    (kp_ready),
        .rx_valid    (rx_valid),
        .rx_char     (rx_char),
        .rx_ready    (rx_ready),
        .btn_valid   (btn_valid),
        .btn_char    (btn_char),
        .result_valid(result_valid),
        .busy        (busy),
        .fifo_level  (fifo_level),
        .drop_cnt    (drop_cnt),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // model state
    logic [7:0] m_q[$];
    bit         m_last_kp;
    bit         m_pend;
    bit         m_wait;
    bit         m_err;
    int         m_wait_t;
    int         m_idle_at;
    int         m_cyc;
    int         m_drop;

    // last sampled DUT outputs
    bit         s_kr, s_rr, s_bv, s_busy, s_err;
    logic [7:0] s_bc, s_drop;
    int         s_lvl;

    typedef struct {
        bit         kv;
        logic [7:0] kc;
        bit         res;
        bit         bv;
        logic [7:0] bc;
        int         lvl;
        bit         busy;
    } vec_t;

    vec_t tab[20];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, m_cyc);
        end
    endtask

    task automatic tfail(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: event not seen within bound (cycle %0d)", nm, m_cyc);
    endtask

    function automatic bit m_legal(input logic [7:0] c);
        string s;
        s = "0123456789+-*=C";
        if (c == 8'h08) return 1'b1;
        for (int i = 0; i < s.len(); i++)
            if (s[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic vec_t mk(input bit kv, input logic [7:0] kc, input bit res,
                                input bit bv, input logic [7:0] bc, input int lvl,
                                input bit bz);
        vec_t v;
        v.kv = kv; v.kc = kc; v.res = res;
        v.bv = bv; v.bc = bc; v.lvl = lvl; v.busy = bz;
        return v;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_last_kp = 1'b0;
        m_pend    = 1'b0;
        m_wait    = 1'b0;
        m_err     = 1'b0;
        m_wait_t  = 0;
        m_idle_at = 0;
        m_cyc     = 0;
        m_drop    = 0;
    endtask

    task automatic do_reset();
        kp_valid = 0; kp_char = 0; rx_valid = 0; rx_char = 0; result_valid = 0;
        rst_n = 1'b0;
        #1;
        chk("rst_kp_ready", kp_ready, 0);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_btn_valid", btn_valid, 0);
        chk("rst_btn_char", btn_char, 0);
        chk("rst_fifo_level", fifo_level, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_err_timeout", err_timeout, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    // One clock of stimulus, compared against the model at the falling edge.
    task automatic cycle(input bit kv, input logic [7:0] kc, input bit rv,
                         input logic [7:0] rc, input bit res);
        int         free, nacc, nst;
        bit         e_kr, e_rr, e_err, e_busy, strobe, ka, ra, kl, rl, clr;
        logic [7:0] hd;
        kp_valid = kv; kp_char = kc;
        rx_valid = rv; rx_char = rc;
        result_valid = res;
        free = DEPTH - m_q.size();
        e_kr = 0;
        e_rr = 0;
        if (free >= 2) begin
            e_kr = 1; e_rr = UART;
        end else if (free == 1) begin
            if (UART && kv && rv) begin
                e_kr = !m_last_kp; e_rr = m_last_kp;
            end else begin
                e_kr = 1; e_rr = UART;
            end
        end
        strobe = m_pend;
        hd     = strobe ? m_q[0] : 8'h00;
        e_err  = m_err && !(strobe && hd == "C");
        e_busy = m_q.size() > 0 || strobe || m_wait || m_cyc < m_idle_at;
        @(negedge clk);
        s_kr = kp_ready; s_rr = rx_ready; s_bv = btn_valid; s_bc = btn_char;
        s_lvl = fifo_level; s_busy = busy; s_drop = drop_cnt; s_err = err_timeout;
        chk("kp_ready", s_kr, e_kr);
        chk("rx_ready", s_rr, e_rr);
        chk("btn_valid", s_bv, strobe);
        chk("btn_char", s_bc, hd);
        chk("fifo_level", s_lvl, m_q.size());
        chk("busy", s_busy, e_busy);
        chk("drop_cnt", s_drop, m_drop);
        chk("err_timeout", s_err, e_err);
        ka = kv && e_kr;
        ra = rv && e_rr;
        if (UART && free == 1 && kv && rv) m_last_kp = ka;
        kl  = ka && m_legal(kc);
        rl  = ra && m_legal(rc);
        clr = (kl && kc == "C") || (rl && rc == "C");
        if (strobe) begin
            void'(m_q.pop_front());
            if (hd == "=") begin
                m_wait = 1; m_wait_t = m_cyc;
            end else begin
                m_idle_at = m_cyc + 1 + GAPC;
            end
            if (hd == "C") m_err = 0;
        end
        if (m_wait && m_cyc > m_wait_t) begin
            if (clr || res) begin
                m_wait = 0; m_idle_at = m_cyc + 1 + GAPC;
            end else if (m_cyc - m_wait_t == RTO) begin
                m_wait = 0; m_err = 1; m_idle_at = m_cyc + 1 + GAPC;
            end
        end
        nacc = int'(ka) + int'(ra);
        if (clr) begin
            m_q.delete();
            m_q.push_back("C");
            nst = 1;
        end else begin
            if (kl) m_q.push_back(kc);
            if (rl) m_q.push_back(rc);
            nst = int'(kl) + int'(rl);
        end
        m_drop = m_drop + nacc - nst;
        if (m_drop > 255) m_drop = 255;
        m_pend = m_cyc >= m_idle_at && !m_wait && m_q.size() > 0;
        m_cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 8'h00, 0, 8'h00, 0);
    endtask

    function automatic logic [7:0] rnd_key();
        string legal;
        int    r;
        legal = "0123456789+-*";
        r = $urandom_range(0, 99);
        if (r < 10) return "=";
        if (r < 13) return "C";
        if (r < 16) return 8'h08;
        if (r < 22) return 8'(8'h61 + $urandom_range(0, 5));
        return legal[$urandom_range(0, 12)];
    endfunction

    initial begin
        bit got;
        int k;

        tab[0]  = mk(1, "1", 0, 0, 8'h00, 0, 0);
        tab[1]  = mk(1, "+", 0, 1, "1",   1, 1);
        tab[2]  = mk(1, "2", 0, 0, 8'h00, 1, 1);
        tab[3]  = mk(1, "=", 0, 0, 8'h00, 2, 1);
        tab[4]  = mk(0, 0,   0, 0, 8'h00, 3, 1);
        tab[5]  = mk(0, 0,   0, 1, "+",   3, 1);
        tab[6]  = mk(0, 0,   0, 0, 8'h00, 2, 1);
        tab[7]  = mk(0, 0,   0, 0, 8'h00, 2, 1);
        tab[8]  = mk(0, 0,   0, 0, 8'h00, 2, 1);
        tab[9]  = mk(0, 0,   0, 1, "2",   2, 1);
        tab[10] = mk(0, 0,   0, 0, 8'h00, 1, 1);
        tab[11] = mk(0, 0,   0, 0, 8'h00, 1, 1);
        tab[12] = mk(0, 0,   0, 0, 8'h00, 1, 1);
        tab[13] = mk(0, 0,   0, 1, "=",   1, 1);
        tab[14] = mk(0, 0,   0, 0, 8'h00, 0, 1);
        tab[15] = mk(0, 0,   0, 0, 8'h00, 0, 1);
        tab[16] = mk(0, 0,   1, 0, 8'h00, 0, 1);
        tab[17] = mk(0, 0,   0, 0, 8'h00, 0, 1);
        tab[18] = mk(0, 0,   0, 0, 8'h00, 0, 1);
        tab[19] = mk(0, 0,   0, 0, 8'h00, 0, 0);

        #2;
        do_reset();

        // "1+2=" typed back to back
        for (int i = 0; i < 20; i++) begin
            cycle(tab[i].kv, tab[i].kc, 0, 8'h00, tab[i].res);
            chk("tab_btn_valid", s_bv, tab[i].bv);
            chk("tab_btn_char", s_bc, tab[i].bc);
            chk("tab_level", s_lvl, tab[i].lvl);
            chk("tab_busy", s_busy, tab[i].busy);
        end

        // illegal key accepted and counted, not stored
        cycle(1, 8'h41, 0, 8'h00, 0);
        chk("illegal_ready", s_kr, 1);
        cycle(0, 8'h00, 0, 8'h00, 0);
        chk("illegal_drop", s_drop, 1);
        chk("illegal_level", s_lvl, 0);

        // result timeout, then cleared by an issued "C"
        cycle(1, "=", 0, 8'h00, 0);
        cycle(0, 8'h00, 0, 8'h00, 0);
        chk("to_issue_eq", s_bc, "=");
        idle(RTO);
        chk("to_err_before", s_err, 0);
        cycle(0, 8'h00, 0, 8'h00, 0);
        chk("to_err_set", s_err, 1);
        cycle(1, "C", 0, 8'h00, 0);
        chk("to_err_held", s_err, 1);
        got = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(0, 8'h00, 0, 8'h00, 0);
            if (s_bv) begin got = 1; break; end
        end
        if (!got) tfail("to_c_issue");
        else begin
            chk("to_c_char", s_bc, "C");
            chk("to_err_clear", s_err, 0);
        end
        idle(4);

`ifdef CALC_SCHED_UART_EN
        // contention at one free slot alternates
        do_reset();
        cycle(1, "=", 0, 8'h00, 0);
        cycle(1, "1", 0, 8'h00, 0);
        cycle(1, "2", 0, 8'h00, 0);
        cycle(1, "3", 0, 8'h00, 0);
        cycle(1, "5", 1, "6", 0);
        chk("rr1_kp_ready", s_kr, 1);
        chk("rr1_rx_ready", s_rr, 0);
        cycle(1, "5", 1, "6", 1);
        chk("full_kp_ready", s_kr, 0);
        chk("full_rx_ready", s_rr, 0);
        k = 0;
        while (m_q.size() != 3 && k < 12) begin
            cycle(1, "5", 1, "6", 0);
            k++;
        end
        if (m_q.size() != 3) tfail("rr2_level3");
        else begin
            cycle(1, "5", 1, "6", 0);
            chk("rr2_kp_ready", s_kr, 0);
            chk("rr2_rx_ready", s_rr, 1);
        end
        idle(40);

        // "C" with a same-cycle UART key aborts the wait and flushes
        do_reset();
        cycle(1, "=", 0, 8'h00, 0);
        cycle(1, "1", 0, 8'h00, 0);
        cycle(1, "2", 0, 8'h00, 0);
        cycle(1, "C", 1, "7", 0);
        chk("clr_kp_ready", s_kr, 1);
        chk("clr_rx_ready", s_rr, 1);
        cycle(0, 8'h00, 0, 8'h00, 0);
        chk("clr_level", s_lvl, 1);
        chk("clr_drop", s_drop, 1);
        got = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(0, 8'h00, 0, 8'h00, 0);
            if (s_bv) begin got = 1; break; end
        end
        if (!got) tfail("clr_issue");
        else chk("clr_char", s_bc, "C");
        idle(4);
`else
        // UART port ignored in the keypad-only build
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(0, 8'h00, 1, "9", 0);
            chk("nouart_rx_ready", s_rr, 0);
            chk("nouart_btn", s_bv, 0);
        end
`endif

        // reset in the middle of an issue strobe
        do_reset();
        cycle(1, "4", 0, 8'h00, 0);
        chk("mid_issue_strobe", btn_valid, 1);
        do_reset();

        // drop counter saturation
        for (int i = 0; i < 260; i++) cycle(1, 8'h61, 0, 8'h00, 0);
        cycle(0, 8'h00, 0, 8'h00, 0);
        chk("drop_sat", s_drop, 255);

        // random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 1) == 1, rnd_key(),
                  $urandom_range(0, 1) == 1, rnd_key(),
                  $urandom_range(0, 19) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
